// File: rtl/tt_um_killer.sv
// Whack-the-LED reaction game: an LFSR lights one of 8 LEDs, the player must hit the matching button before timeout.
// Define KILLER_STREAK_EN to award a +2 bonus on every fourth consecutive hit.
//
// state    | meaning
// S_IDLE   | waiting for first start press, display dark
// S_PLAY   | target shown on uo_out, timer running
// S_OVER   | lives exhausted, uo_out shows {1, score}
module tt_um_killer #(
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          LIVES          = 3,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int             TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]     LIVES_INIT = 3'(LIVES);
   localparam logic [15:0]    LFSR_TAPS  = 16'hB400;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

   state_t          state, state_nxt;
   logic [6:0]      score, score_nxt;
   logic [2:0]      lives, lives_nxt;
   logic [15:0]     lfsr, lfsr_nxt;
   logic [7:0]      target, target_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic [7:0]      btn_prev;
   logic            start_prev;
   logic [7:0]      press;
   logic            start_edge;
   logic            hit, miss, issue;
`ifdef KILLER_STREAK_EN
   logic [1:0]      streak, streak_nxt;
`endif

   logic unused_uio;
   assign unused_uio = &{1'b0, uio_in[7:1]};

   assign press      = ui_in & ~btn_prev;
   assign start_edge = uio_in[0] & ~start_prev;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= S_IDLE;
         score      <= 7'd0;
         lives      <= LIVES_INIT;
         lfsr       <= LFSR_SEED;
         target     <= 8'd0;
         timer      <= '0;
         btn_prev   <= 8'd0;
         start_prev <= 1'b0;
`ifdef KILLER_STREAK_EN
         streak     <= 2'd0;
`endif
      end else if (ena) begin
         state      <= state_nxt;
         score      <= score_nxt;
         lives      <= lives_nxt;
         lfsr       <= lfsr_nxt;
         target     <= target_nxt;
         timer      <= timer_nxt;
         btn_prev   <= ui_in;
         start_prev <= uio_in[0];
`ifdef KILLER_STREAK_EN
         streak     <= streak_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      score_nxt  = score;
      lives_nxt  = lives;
      lfsr_nxt   = lfsr;
      target_nxt = target;
      timer_nxt  = timer;
      hit        = 1'b0;
      miss       = 1'b0;
      issue      = 1'b0;
`ifdef KILLER_STREAK_EN
      streak_nxt = streak;
`endif
      case (state)
         S_IDLE, S_OVER: begin
            if (start_edge) begin
               score_nxt = 7'd0;
               lives_nxt = LIVES_INIT;
               timer_nxt = '0;
               issue     = 1'b1;
               state_nxt = S_PLAY;
`ifdef KILLER_STREAK_EN
               streak_nxt = 2'd0;
`endif
            end
         end
         S_PLAY: begin
            timer_nxt = timer + 1'b1;
            if (press != 8'd0) begin
               if (press == target) hit = 1'b1;
               else                 miss = 1'b1;
            end else if (timer == TIMER_LAST) begin
               miss = 1'b1;
            end
            if (hit) begin
`ifdef KILLER_STREAK_EN
               if (streak == 2'd3) begin
                  score_nxt  = (score >= 7'd126) ? 7'd127 : score + 7'd2;
                  streak_nxt = 2'd0;
               end else begin
                  score_nxt  = (score == 7'd127) ? score : score + 7'd1;
                  streak_nxt = streak + 2'd1;
               end
`else
               score_nxt = (score == 7'd127) ? score : score + 7'd1;
`endif
            end
            if (hit || miss) begin
               timer_nxt = '0;
               issue     = 1'b1;
            end
            if (miss) begin
`ifdef KILLER_STREAK_EN
               streak_nxt = 2'd0;
`endif
               // Last life: no new target, the LFSR keeps its value for the next game.
               if (lives == 3'd1) begin
                  lives_nxt = 3'd0;
                  issue     = 1'b0;
                  state_nxt = S_OVER;
               end else begin
                  lives_nxt = lives - 3'd1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (issue) begin
         target_nxt = 8'd1 << lfsr[2:0];
         lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
      if (state_nxt == S_OVER && state == S_PLAY) target_nxt = 8'd0;
   end

   always_comb begin
      uo_out = 8'd0;
      case (state)
         S_PLAY:  uo_out = target;
         S_OVER:  uo_out = {1'b1, score};
         default: uo_out = 8'd0;
      endcase
   end

   assign uio_out = {score, (state == S_PLAY)};
   assign uio_oe  = 8'hFE;

endmodule

// File: tb/tb_tt_um_killer.sv
// Bench for tt_um_killer: directed scenarios plus random play against an integer game model.
module tb_tt_um_killer;

   localparam int T  = 16;
   localparam int NL = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int total = 0;
   int bad   = 0;

   // game model: mode 0 idle, 1 playing, 2 game over
   int m_mode, m_score, m_lives, m_lfsr, m_target, m_timer, m_btn, m_start, m_streak;

   tt_um_killer #(.TIMEOUT_CYCLES(T), .LIVES(NL), .LFSR_SEED(16'hACE1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_mode = 0; m_score = 0; m_lives = NL; m_lfsr = 'hACE1;
      m_target = 0; m_timer = 0; m_btn = 0; m_start = 0; m_streak = 0;
   endtask

   task automatic m_issue();
      m_target = 1 << (m_lfsr % 8);
      m_lfsr   = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
   endtask

   task automatic m_step(input int ui, input int st);
      int press, sedge;
      press   = ui & ~m_btn & 'hFF;
      sedge   = st & ~m_start & 1;
      m_btn   = ui;
      m_start = st;
      if (m_mode != 1) begin
         if (sedge != 0) begin
            m_score = 0; m_lives = NL; m_timer = 0; m_streak = 0;
            m_issue();
            m_mode = 1;
         end
      end else begin
         bit hit, miss;
         hit  = (press != 0) && (press == m_target);
         miss = ((press != 0) && (press != m_target)) || ((press == 0) && (m_timer == T - 1));
         if (hit) begin
`ifdef KILLER_STREAK_EN
            if (m_streak == 3) begin
               m_score = (m_score + 2 > 127) ? 127 : m_score + 2;
               m_streak = 0;
            end else begin
               m_score = (m_score + 1 > 127) ? 127 : m_score + 1;
               m_streak++;
            end
`else
            m_score = (m_score + 1 > 127) ? 127 : m_score + 1;
`endif
            m_timer = 0;
            m_issue();
         end else if (miss) begin
            m_streak = 0;
            m_timer  = 0;
            if (m_lives == 1) begin
               m_lives = 0; m_target = 0; m_mode = 2;
            end else begin
               m_lives--;
               m_issue();
            end
         end else begin
            m_timer++;
         end
      end
   endtask

   function automatic int exp_uo();
      if (m_mode == 1) return m_target;
      if (m_mode == 2) return 128 + m_score;
      return 0;
   endfunction

   function automatic int exp_uio();
      return m_score * 2 + ((m_mode == 1) ? 1 : 0);
   endfunction

   task automatic cyc(input string tag);
      @(posedge clk);
      if (!rst_n && ena) m_step(int'(ui_in), int'(uio_in[0]));
      #1;
      chk({tag, "_uo"}, int'(uo_out), exp_uo());
      chk({tag, "_uio"}, int'(uio_out), exp_uio());
   endtask

   initial begin
      int tgt0, sc0, r;
      logic [7:0] uo_snap, uio_snap;
      rst_n = 1'b1; ena = 1'b1; ui_in = 8'd0; uio_in = 8'd0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_uo", int'(uo_out), 0);
      chk("rst_uio", int'(uio_out), 0);
      chk("rst_oe", int'(uio_oe), 'hFE);
      @(negedge clk) rst_n = 1'b0;
      cyc("idle");

      uio_in = 8'h01; cyc("start");
      chk("start_uo_const", int'(uo_out), 'h02);
      chk("start_uio_const", int'(uio_out), 'h01);
      ui_in = 8'h02; cyc("hit");
      chk("hit_uio_const", int'(uio_out), 'h03);
      chk("hit_uo_const", int'(uo_out), 'h01);
      for (int i = 0; i < 3; i++) begin
         ui_in = 8'h00; cyc("rel");
         ui_in = 8'h80; cyc("wrong");
      end
      chk("over_uo_const", int'(uo_out), 'h81);
      chk("over_uio_const", int'(uio_out), 'h02);

      // timeout, then press winning against the timeout
      ui_in = 8'h00; uio_in = 8'h00; cyc("rel2");
      uio_in = 8'h01; cyc("restart");
      chk("restart_play", int'(uio_out[0]), 1);
      tgt0 = m_target;
      repeat (T - 1) cyc("wait");
      chk("pre_timeout_tgt", int'(uo_out), tgt0);
      cyc("timeout");
      chk("timeout_play", int'(uio_out[0]), 1);
      repeat (T - 1) cyc("wait2");
      sc0 = m_score;
      ui_in = 8'(m_target); cyc("press_vs_timeout");
      chk("press_wins", int'(uio_out[7:1]), sc0 + 1);
      ui_in = 8'h00; cyc("rel3");

      // freeze with ena low
      uo_snap = uo_out; uio_snap = uio_out;
      ena = 1'b0;
      for (int i = 0; i < 50; i++) begin
         ui_in = 8'($urandom); uio_in = 8'($urandom);
         cyc("frozen");
      end
      chk("freeze_uo", int'(uo_out), int'(uo_snap));
      chk("freeze_uio", int'(uio_out), int'(uio_snap));
      ui_in = 8'h00; uio_in = 8'h00; cyc("thaw");
      ena = 1'b1;
      cyc("resume");

      // async reset mid-game
      @(negedge clk); #2 rst_n = 1'b1;
      #1;
      chk("async_rst_uo", int'(uo_out), 0);
      chk("async_rst_uio", int'(uio_out), 0);
      m_reset();
      @(negedge clk) rst_n = 1'b0;

      // score saturation and multi-button miss
      uio_in = 8'h01; cyc("sat_start");
      uio_in = 8'h00;
      for (int i = 0; i < 132; i++) begin
         ui_in = 8'(m_target); cyc("sat_hit");
         ui_in = 8'h00; cyc("sat_rel");
      end
      chk("score_sat", int'(uio_out[7:1]), 127);
      ui_in = 8'hFF; cyc("multi_btn");
      chk("multi_btn_score", int'(uio_out[7:1]), 127);
      ui_in = 8'h00; cyc("multi_rel");

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         ena = ($urandom_range(0, 99) < 92);
         r = $urandom_range(0, 99);
         if (r < 50)      ui_in = 8'h00;
         else if (r < 75) ui_in = 8'(m_target);
         else if (r < 90) ui_in = 8'(1 << $urandom_range(0, 7));
         else             ui_in = 8'($urandom_range(0, 255));
         uio_in = {7'($urandom), ($urandom_range(0, 19) == 0)};
         cyc("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tt_um_killer.md
Name: tt_um_killer

Overview:
- TinyTapeout user block implementing a single-player "whack-the-LED" reaction game.
- A 16-bit LFSR picks one of 8 target LEDs on uo_out; the player must press the matching button on ui_in before a timeout.
- Hits increment a 7-bit score; misses or timeouts cost a life. The game ends when lives reach zero.

Parameters:
- TIMEOUT_CYCLES, 1000, clock cycles allowed per target (minimum 2).
- LIVES, 3, lives at game start (1..7).
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock domain; reset is asynchronous and active-high (port name kept for harness compatibility; asserted = 1)
- ena  input  1  clock enable; 0 freezes all state
- ui_in  input  8  player buttons, one per LED, active-high
- uo_out  output  8  one-hot target LED / game-over display
- uio_in  input  8  bit0 = start; bits 7:1 ignored
- uio_out  output  8  bits 7:1 = score[6:0]; bit0 = playing flag
- uio_oe  output  8  constant 8'hFE

Behaviour:
- Reset (rst_n=1, async) sets:
  - state IDLE, score 0, lives LIVES
  - lfsr LFSR_SEED, target 0, timer 0
  - btn_prev 0, start_prev 0
- Outputs after reset: uo_out=00, uio_out=00.
- All registers update only on a clk rising edge with ena=1. With ena=0 everything holds, including the edge-detect registers.
- Edge detection:
  - press = ui_in & ~btn_prev
  - start_edge = uio_in[0] & ~start_prev
  - Both previous-value registers update every enabled cycle.
- LFSR: Galois, right shift, taps 16'hB400. It steps only when a new target is issued. The new target is 1 << lfsr[2:0], using the value before the step.
- IDLE:
  - uo_out=00, uio_out[0]=0.
  - start_edge → score=0, lives=LIVES, timer=0, issue target, go to PLAY.
- PLAY:
  - uo_out=target, uio_out[0]=1. timer increments each cycle.
  - press≠0 and press==target → hit: score+1, saturating at 127.
  - press≠0 and press≠target (including multi-button presses) → miss.
  - press==0 and timer==TIMEOUT_CYCLES-1 → miss (timeout).
  - A press has priority over timeout in the same cycle.
  - Any hit or miss: timer=0, new target issued on the same edge; the next cycle shows the new target.
  - Miss with lives==1 → lives=0, target=0, go to GAMEOVER. Otherwise lives-1.
  - start_edge during PLAY is ignored.
- GAMEOVER:
  - uo_out = {1'b1, score[6:0]}, uio_out[0]=0.
  - start_edge → new game exactly as from IDLE. The LFSR continues from its current value and is not reseeded.
- Latency: a button rising before edge k is scored at edge k; new uo_out/uio_out are visible after edge k.
- uio_out[7:1] shows score in all states.
- Reset asserted mid-game aborts immediately to IDLE.

Optional Feature:
- Macro KILLER_STREAK_EN.
- Defined:
  - 2-bit streak counter, reset 0, also cleared on any miss and on game start.
  - Each hit increments the streak.
  - A hit that completes 4 consecutive hits adds 2 to score (saturating at 127) and clears the streak.
- Undefined: no streak logic; every hit adds exactly 1.

Test Plan:
- Reset: rst_n=1 then 0, ena=1 → uo_out=00, uio_out=00, uio_oe=FE.
- Start pulse uio_in[0] 0→1 → next cycle uo_out=02, uio_out=01 (LFSR goes ACE1→E270).
- In PLAY with target 02, press ui_in=02 → uio_out=03 (score 1), uo_out=01.
- Three wrong presses of 0x80, released between presses → after the third, GAMEOVER with uo_out=81, uio_out=02.
- No press for TIMEOUT_CYCLES cycles → one life lost, new target shown, timer restarts. Press and timeout in the same cycle → press wins.
- ena=0 for 50 cycles in PLAY with buttons toggling → no state or output change. Reset mid-PLAY → IDLE outputs immediately (asynchronous).
